// File: rtl/zircon_ip_cksum_check_if.sv
// AXI-Stream packet channel used on both sides of the checksum checker.
interface zircon_ip_cksum_check_if #(
   parameter int DATA_W = 64,
   parameter int KEEP_W = DATA_W / 8,
   parameter int USER_W = 1
);
   logic [DATA_W-1:0] tdata;
   logic [KEEP_W-1:0] tkeep;
   logic              tlast;
   logic [USER_W-1:0] tuser;
   logic              tvalid;
   logic              tready;

   modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
   modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/zircon_ip_cksum_check.sv
// Buffers RX packet beats, holds each last beat until its {csum,len} metadata
// arrives, then tags it with checksum/length error flags and counts errors.
module zircon_ip_cksum_check #(
   parameter int          DATA_W    = 64,
   parameter int          KEEP_W    = DATA_W / 8,
   parameter int          USER_W    = 1,
   parameter int          FIFO_AW   = 6,
   parameter int          META_AW   = 3,
   parameter logic [15:0] CSUM_GOOD = 16'hFFFF,
   parameter logic [15:0] MIN_LEN   = 16'd60
) (
   input  logic                    clk,
   input  logic                    rst_n,
   zircon_ip_cksum_check_if.slave  s_axis_pkt,
   input  logic [31:0]             s_axis_meta_tdata,
   input  logic                    s_axis_meta_tvalid,
   output logic                    s_axis_meta_tready,
   zircon_ip_cksum_check_if.master m_axis_pkt,
   output logic [31:0]             stat_csum_err_cnt,
   output logic [31:0]             stat_len_err_cnt,
   output logic [31:0]             stat_pkt_cnt
);
   if (DATA_W != KEEP_W * 8 || DATA_W % 32 != 0) begin : g_bad_param
      $fatal(1, "zircon_ip_cksum_check: DATA_W must equal KEEP_W*8 and be a multiple of 32");
   end

   localparam int PDEPTH = 1 << FIFO_AW;
   localparam int MDEPTH = 1 << META_AW;
   localparam logic [FIFO_AW:0] PONE    = {{FIFO_AW{1'b0}}, 1'b1};
   localparam logic [META_AW:0] MONE    = {{META_AW{1'b0}}, 1'b1};
   localparam logic [META_AW:0] MAX_OUT = {1'b1, {META_AW{1'b0}}};

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [KEEP_W-1:0] keep;
      logic              last;
      logic [USER_W-1:0] user;
   } beat_t;

   typedef enum logic [1:0] {IDLE, STREAM, WAIT_META} state_t;

   logic [1:0]       rst_sync;
   logic             run;
   beat_t            mem [PDEPTH];
   logic [31:0]      meta_mem [MDEPTH];
   beat_t            in_beat, hd_q, hd_d;
   logic             hd_vld_q, hd_vld_d;
   logic [FIFO_AW:0] wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
   logic [META_AW:0] mwr_ptr, mrd_ptr, mwr_ptr_d, mrd_ptr_d;
   logic [META_AW:0] outst_q, outst_d;
   state_t           state_q, state_d;
   logic             pfull, pempty, mfull, mempty;
   logic             in_acc, meta_wr, xfer, last_xfer, mem_we, bypass;
   logic             meta_ovf;
   logic [31:0]      meta_hd;
   logic             csum_err, len_err;

   // Release is delayed two edges so nothing is accepted on a half-settled reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync <= 2'b00;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end
   assign run = rst_sync[1];

   assign pempty  = (wr_ptr == rd_ptr);
   assign pfull   = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                    (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
   assign mempty  = (mwr_ptr == mrd_ptr);
   assign mfull   = (mwr_ptr[META_AW] != mrd_ptr[META_AW]) &&
                    (mwr_ptr[META_AW-1:0] == mrd_ptr[META_AW-1:0]);
   assign meta_hd = meta_mem[mrd_ptr[META_AW-1:0]];
   assign csum_err = (meta_hd[31:16] != CSUM_GOOD);
   assign len_err  = (meta_hd[15:0] < MIN_LEN);

   assign s_axis_pkt.tready  = run && !pfull && (outst_q < MAX_OUT);
   assign s_axis_meta_tready = 1'b1;
   assign in_acc  = s_axis_pkt.tvalid && s_axis_pkt.tready;
   assign meta_wr = s_axis_meta_tvalid && run && !mfull;
   assign in_beat = {s_axis_pkt.tdata, s_axis_pkt.tkeep, s_axis_pkt.tlast, s_axis_pkt.tuser};

   assign m_axis_pkt.tvalid = (state_q == STREAM);
   assign m_axis_pkt.tdata  = hd_q.data;
   assign m_axis_pkt.tkeep  = hd_q.keep;
   assign m_axis_pkt.tlast  = hd_q.last;
   assign m_axis_pkt.tuser  = {(m_axis_pkt.tvalid && hd_q.last) ? {len_err, csum_err} : 2'b00,
                               hd_q.user};
   assign xfer      = m_axis_pkt.tvalid && m_axis_pkt.tready;
   assign last_xfer = xfer && hd_q.last;

   // Head register refills from the FIFO, or straight from the input when the FIFO is empty.
   always_comb begin
      hd_d     = hd_q;
      hd_vld_d = hd_vld_q;
      rd_ptr_d = rd_ptr;
      wr_ptr_d = wr_ptr;
      mem_we   = 1'b0;
      bypass   = 1'b0;
      if (!hd_vld_q || xfer) begin
         if (!pempty) begin
            hd_d     = mem[rd_ptr[FIFO_AW-1:0]];
            hd_vld_d = 1'b1;
            rd_ptr_d = rd_ptr + PONE;
         end else if (in_acc) begin
            hd_d     = in_beat;
            hd_vld_d = 1'b1;
            bypass   = 1'b1;
         end else begin
            hd_vld_d = 1'b0;
         end
      end
      if (in_acc && !bypass) begin
         mem_we   = 1'b1;
         wr_ptr_d = wr_ptr + PONE;
      end
      mwr_ptr_d = meta_wr   ? mwr_ptr + MONE : mwr_ptr;
      mrd_ptr_d = last_xfer ? mrd_ptr + MONE : mrd_ptr;
      outst_d   = outst_q;
      if (in_acc && s_axis_pkt.tlast && !last_xfer)      outst_d = outst_q + MONE;
      else if (last_xfer && !(in_acc && s_axis_pkt.tlast)) outst_d = outst_q - MONE;
      // Metadata written this cycle only counts from the next cycle on.
      if (!hd_vld_d)                                   state_d = IDLE;
      else if (hd_d.last && (mwr_ptr_d == mrd_ptr_d))  state_d = WAIT_META;
      else                                             state_d = STREAM;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hd_q     <= '0;
         hd_vld_q <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         mwr_ptr  <= '0;
         mrd_ptr  <= '0;
         outst_q  <= '0;
         state_q  <= IDLE;
         meta_ovf <= 1'b0;
      end else begin
         hd_q     <= hd_d;
         hd_vld_q <= hd_vld_d;
         wr_ptr   <= wr_ptr_d;
         rd_ptr   <= rd_ptr_d;
         mwr_ptr  <= mwr_ptr_d;
         mrd_ptr  <= mrd_ptr_d;
         outst_q  <= outst_d;
         state_q  <= state_d;
         if (s_axis_meta_tvalid && run && mfull) meta_ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we)  mem[wr_ptr[FIFO_AW-1:0]]       <= in_beat;
      if (meta_wr) meta_mem[mwr_ptr[META_AW-1:0]] <= s_axis_meta_tdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_csum_err_cnt <= '0;
         stat_len_err_cnt  <= '0;
         stat_pkt_cnt      <= '0;
      end else if (last_xfer) begin
         stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
         if (csum_err && stat_csum_err_cnt != 32'hFFFF_FFFF)
            stat_csum_err_cnt <= stat_csum_err_cnt + 32'd1;
         if (len_err && stat_len_err_cnt != 32'hFFFF_FFFF)
            stat_len_err_cnt <= stat_len_err_cnt + 32'd1;
      end
   end

   a_no_meta_ovf: assert property (@(posedge clk) disable iff (!rst_n) !meta_ovf);
endmodule

// File: tb/tb_zircon_ip_cksum_check.sv
// Directed bench for zircon_ip_cksum_check with an in-order expected-beat queue.
module tb_zircon_ip_cksum_check;
   localparam int DW = 64;
   localparam int UW = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   zircon_ip_cksum_check_if #(.DATA_W(DW), .USER_W(UW))     s_pkt ();
   zircon_ip_cksum_check_if #(.DATA_W(DW), .USER_W(UW + 2)) m_pkt ();

   logic [31:0] meta_data = '0;
   logic        meta_vld  = 1'b0;
   logic        meta_rdy;
   logic [31:0] csum_cnt, len_cnt, pkt_cnt;

   zircon_ip_cksum_check #(.DATA_W(DW), .USER_W(UW), .FIFO_AW(6), .META_AW(3)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .s_axis_pkt         (s_pkt),
      .s_axis_meta_tdata  (meta_data),
      .s_axis_meta_tvalid (meta_vld),
      .s_axis_meta_tready (meta_rdy),
      .m_axis_pkt         (m_pkt),
      .stat_csum_err_cnt  (csum_cnt),
      .stat_len_err_cnt   (len_cnt),
      .stat_pkt_cnt       (pkt_cnt)
   );

   typedef struct packed {
      logic [DW-1:0] data;
      logic [7:0]    keep;
      logic          last;
      logic [UW+1:0] user;
   } exp_t;

   exp_t exp_q[$];
   exp_t e_mon;
   int   n_chk = 0, n_pass = 0, n_seen = 0;
   logic tog_en = 1'b0, rdy_set = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Single driver of the output-side ready: fixed level or random 50% toggling.
   always @(posedge clk) begin
      #1;
      if (tog_en) m_pkt.tready = 1'($urandom_range(0, 1));
      else        m_pkt.tready = rdy_set;
   end

   always @(negedge clk) begin
      if (rst_n && m_pkt.tvalid && m_pkt.tready) begin
         if (exp_q.size() == 0) chk("unexpected_beat", 64'(m_pkt.tdata), 64'hDEAD);
         else begin
            e_mon = exp_q.pop_front();
            chk("data", 64'(m_pkt.tdata), 64'(e_mon.data));
            chk("keep_last", 64'({m_pkt.tkeep, m_pkt.tlast}), 64'({e_mon.keep, e_mon.last}));
            chk("tuser", 64'(m_pkt.tuser), 64'(e_mon.user));
            n_seen++;
         end
      end
   end

   task automatic put_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                           input logic u, input logic [1:0] fl, input int maxw, output bit ok);
      s_pkt.tdata  = d;
      s_pkt.tkeep  = k;
      s_pkt.tlast  = l;
      s_pkt.tuser  = u;
      s_pkt.tvalid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < maxw; i++) begin
         @(negedge clk);
         if (s_pkt.tready) begin ok = 1'b1; break; end
      end
      if (ok) exp_q.push_back('{d, k, l, {(l ? fl : 2'b00), u}});
      @(posedge clk); #1;
      s_pkt.tvalid = 1'b0;
   endtask

   task automatic send_pkt(input int n, input logic [63:0] base, input logic [1:0] fl);
      bit ok;
      for (int i = 0; i < n; i++) begin
         put_beat(base + 64'(i), (i == n - 1) ? 8'h0F : 8'hFF, i == n - 1, i[0], fl, 3000, ok);
         chk("accept", 64'(ok), 64'd1);
      end
   endtask

   task automatic send_meta(input logic [15:0] cs, input logic [15:0] ln);
      meta_data = {cs, ln};
      meta_vld  = 1'b1;
      @(posedge clk); #1;
      meta_vld  = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
      chk("drain", 64'(exp_q.size()), 64'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int acc, seen0;
      logic [15:0] cs, ln;
      s_pkt.tvalid = 1'b0; s_pkt.tdata = '0; s_pkt.tkeep = '0; s_pkt.tlast = 1'b0; s_pkt.tuser = '0;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tvalid", 64'(m_pkt.tvalid), 64'd0);
      chk("rst_tready", 64'(s_pkt.tready), 64'd0);
      chk("rst_tuser", 64'(m_pkt.tuser), 64'd0);
      chk("rst_cnts", 64'({csum_cnt, len_cnt} | 64'(pkt_cnt)), 64'd0);
      chk("meta_rdy", 64'(meta_rdy), 64'd1);
      @(negedge clk); rst_n = 1'b1;
      rdy_set = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // 8-beat good packet; the last beat must wait for metadata plus one cycle
      send_pkt(8, 64'h1000, 2'b00);
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("hold_tvalid", 64'(m_pkt.tvalid), 64'd0);
      chk("hold_pending", 64'(exp_q.size()), 64'd1);
      @(posedge clk); #1;
      meta_data = {16'hFFFF, 16'd64}; meta_vld = 1'b1;
      @(negedge clk);
      chk("meta_same_cycle", 64'(m_pkt.tvalid), 64'd0);
      @(posedge clk); #1;
      meta_vld = 1'b0;
      @(negedge clk);
      chk("meta_next_cycle", 64'(m_pkt.tvalid), 64'd1);
      wait_drain();
      chk("t1_pkt", 64'(pkt_cnt), 64'd1);
      chk("t1_csum", 64'(csum_cnt), 64'd0);

      // bad checksum and short length
      send_pkt(2, 64'h2000, 2'b11);
      send_meta(16'h1234, 16'd40);
      wait_drain();
      chk("t2_pkt", 64'(pkt_cnt), 64'd2);
      chk("t2_csum", 64'(csum_cnt), 64'd1);
      chk("t2_len", 64'(len_cnt), 64'd1);

      // outstanding limit: 8 one-beat packets with output stalled
      rdy_set = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      acc = 0;
      for (int i = 0; i < 10; i++) begin
         cs = (i % 3 == 0) ? 16'h0BAD : 16'hFFFF;
         ln = (i % 2 == 1) ? 16'd20 : 16'd100;
         put_beat(64'h3000 + 64'(i), 8'hFF, 1'b1, 1'b1, {ln < 16'd60, cs != 16'hFFFF}, 3, ok);
         if (!ok) break;
         acc++;
         send_meta(cs, ln);
      end
      chk("acc_limit", 64'(acc), 64'd8);
      @(negedge clk);
      chk("in_rdy_low", 64'(s_pkt.tready), 64'd0);
      rdy_set = 1'b1;
      wait_drain();
      chk("t3_pkt", 64'(pkt_cnt), 64'd10);
      chk("t3_csum", 64'(csum_cnt), 64'd4);
      chk("t3_len", 64'(len_cnt), 64'd5);

      // 74-beat packet: fill the FIFO completely, then drain with random ready
      rdy_set = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      seen0 = n_seen;
      fork
         begin
            repeat (75) @(negedge clk);
            chk("fifo_full", 64'(s_pkt.tready), 64'd0);
            tog_en = 1'b1;
         end
      join_none
      send_pkt(74, 64'h4000, 2'b00);
      send_meta(16'hFFFF, 16'd600);
      wait_drain();
      tog_en = 1'b0; rdy_set = 1'b1;
      chk("t4_beats", 64'(n_seen - seen0), 64'd74);
      chk("t4_pkt", 64'(pkt_cnt), 64'd11);

      // reset in the middle of a packet with metadata still pending
      rdy_set = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         put_beat(64'h5000 + 64'(i), 8'hFF, 1'b0, 1'b0, 2'b00, 100, ok);
         chk("t5_accept", 64'(ok), 64'd1);
      end
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_tvalid", 64'(m_pkt.tvalid), 64'd0);
      chk("t5_rst_tready", 64'(s_pkt.tready), 64'd0);
      exp_q.delete();
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("t5_sync_edge1", 64'(s_pkt.tready), 64'd0);
      @(posedge clk); #1;
      chk("t5_sync_edge2", 64'(s_pkt.tready), 64'd1);
      chk("t5_cnt_clear", 64'(pkt_cnt), 64'd0);
      rdy_set = 1'b1;
      send_pkt(2, 64'h6000, 2'b00);
      send_meta(16'hFFFF, 16'd60);
      wait_drain();
      chk("t5_pkt", 64'(pkt_cnt), 64'd1);
      chk("t5_csum", 64'(csum_cnt), 64'd0);

      // checksum-error counter saturation
      force dut.stat_csum_err_cnt = 32'hFFFF_FFFD;
      #2 release dut.stat_csum_err_cnt;
      @(negedge clk);
      chk("t6_preset", 64'(csum_cnt), 64'hFFFF_FFFD);
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         send_pkt(1, 64'h7000 + 64'(i), 2'b01);
         send_meta(16'h0000, 16'd100);
      end
      wait_drain();
      chk("t6_sat", 64'(csum_cnt), 64'hFFFF_FFFF);
      chk("t6_len", 64'(len_cnt), 64'd0);
      chk("t6_pkt", 64'(pkt_cnt), 64'd4);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/zircon_ip_cksum_check.md
Name: zircon_ip_cksum_check

Overview:
- Sits directly downstream of the Zircon length/checksum stage.
- Consumes its packet passthrough stream and its per-packet metadata word ({csum[31:16], len[15:0]}).
- Buffers packet beats in a FIFO, holds each packet's last beat until that packet's metadata arrives, then emits the last beat tagged with checksum-error and length-error flags.
- Also keeps saturating error counters for the RX path.

Parameters:
- DATA_W, 64, packet data width in bits; must be a multiple of 32.
- KEEP_W, DATA_W/8, tkeep width; DATA_W must equal KEEP_W*8 (fatal otherwise).
- USER_W, 1, width of input tuser.
- FIFO_AW, 6, packet FIFO depth is 2**FIFO_AW beats.
- META_AW, 3, meta FIFO depth is 2**META_AW entries, which is also the maximum number of outstanding packets.
- CSUM_GOOD, 16'hFFFF, metadata csum value that indicates a good checksum.
- MIN_LEN, 16'd60, a metadata len below this value flags a length error.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_axis_pkt_tdata  in  DATA_W  packet data
- s_axis_pkt_tkeep  in  KEEP_W  byte enables
- s_axis_pkt_tlast  in  1  end of packet
- s_axis_pkt_tuser  in  USER_W  sideband, passed through
- s_axis_pkt_tvalid  in  1  beat valid
- s_axis_pkt_tready  out  1  beat accepted
- s_axis_meta_tdata  in  32  {csum, len}
- s_axis_meta_tvalid  in  1  single-cycle metadata pulse
- s_axis_meta_tready  out  1  tied 1
- m_axis_pkt_tdata  out  DATA_W  packet data
- m_axis_pkt_tkeep  out  KEEP_W  byte enables
- m_axis_pkt_tlast  out  1  end of packet
- m_axis_pkt_tuser  out  USER_W+2  {len_err, csum_err, tuser}; the two flag bits are nonzero only on the last beat
- m_axis_pkt_tvalid  out  1  beat valid
- m_axis_pkt_tready  in  1  downstream ready
- stat_csum_err_cnt  out  32  saturating count of packets with csum_err
- stat_len_err_cnt  out  32  saturating count of packets with len_err
- stat_pkt_cnt  out  32  wrapping count of packets emitted

Behaviour:
- Reset: rst_n low asynchronously clears the following.
  - FIFO pointers, outstanding counter, meta FIFO, state (IDLE) and all counters.
  - m_axis_pkt_tvalid=0, s_axis_pkt_tready=0 while reset is asserted; other outputs = 0.
  - Release is synchronised internally: tready may rise no earlier than the second clk edge after deassertion.
  - Reset mid-packet discards all buffered beats and metadata; no partial packet is emitted after reset.
- Input acceptance:
  - s_axis_pkt_tready = !pkt_fifo_full && (outstanding < 2**META_AW).
  - outstanding increments on an accepted last beat and decrements when an output last beat completes; both in the same cycle leave it unchanged.
- Metadata:
  - Always accepted. The meta FIFO write happens on tvalid.
  - Space is guaranteed by the outstanding limit. A write while the meta FIFO is full is a protocol violation; the write is dropped and a sticky internal overflow flag is set for assertions.
- Packet FIFO:
  - Registered output.
  - A beat written into an empty FIFO appears at m_axis_pkt_tvalid on the next cycle, giving 1-cycle minimum latency.
  - Full and empty are derived from FIFO_AW+1-bit pointers; wrap-around is correct at 2**FIFO_AW.
- Output FSM:
  - IDLE/STREAM: FIFO head beats with tlast=0 are presented whenever available and transfer on tvalid&&tready.
  - At a head beat with tlast=1, m_axis_pkt_tvalid is held low until the meta FIFO is non-empty (WAIT_META).
  - When metadata is present, the last beat is presented with:
    - csum_err = (csum != CSUM_GOOD)
    - len_err = (len < MIN_LEN)
  - The meta entry is popped in the same cycle the last beat transfers.
  - Metadata arriving in the same cycle the FSM checks for it is not visible until the next cycle (one extra cycle maximum).
- Output stability: once m_axis_pkt_tvalid=1, tdata/tkeep/tlast/tuser stay stable until tready (AXI-Stream rule).
- Counters:
  - Update on output last-beat transfer.
  - The error counters saturate at 32'hFFFFFFFF; stat_pkt_cnt wraps.
- Ordering: packets and metadata are strictly in order; the n-th meta entry pairs with the n-th packet.

Test Plan:
- Single 64-byte packet (8 beats, DATA_W=64); meta {16'hFFFF,16'd64} pulsed 3 cycles after last -> 8 beats out in order, last beat held until meta+1 cycle, tuser flags 2'b00, stat_pkt_cnt=1.
- Meta csum=16'h1234, len=16'd40 -> last beat tuser[USER_W+1:USER_W]=2'b11; stat_csum_err_cnt=1, stat_len_err_cnt=1.
- Back-to-back 1-beat packets with m_axis_pkt_tready=0, META_AW=3 -> s_axis_pkt_tready drops after 8 accepted last beats; releasing tready drains 8 packets with correct meta pairing.
- 2**FIFO_AW+10 beat packet, tready toggling 50% -> FIFO fill/wrap without loss or duplication; data matches a reference model.
- rst_n asserted mid-packet (beat 3 of 8, meta pending) -> tvalid=0 immediately; after release, a new packet passes clean with counters restarted at 0.
- Force stat_csum_err_cnt near 32'hFFFFFFFE, send 3 bad packets -> counter holds at 32'hFFFFFFFF.
